// File: rtl/gmem_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gmem_fifo_pkg
// Description : Shared constants and helpers for the m_axi buffering FIFO
//               controller (gmem_fifo_ctrl). Provides the default geometry,
//               the RAM word count, the occupancy counter width and the
//               non-power-of-two pointer increment.
// Revision    : 1.0 - initial release
// ============================================================================
package gmem_fifo_pkg;

  // Default geometry of the generated kernel's buffer
  localparam int DEFAULT_DEPTH      = 63;
  localparam int DEFAULT_ADDR_WIDTH = 6;

  // One word lives in the output holding stage, the rest in RAM
  localparam int RAM_WORDS = DEFAULT_DEPTH - 1;

  // Occupancy counters span 0..2**ADDR_WIDTH, hence one extra bit
  localparam int OCC_WIDTH = DEFAULT_ADDR_WIDTH + 1;

  // RAM pointer increment; the RAM holds depth-1 words (addresses
  // 0..depth-2), which is generally not a power of two, so the wrap is an
  // explicit compare rather than a natural bit overflow.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
    return (ptr == 32'(depth - 2)) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage : gmem_fifo_pkg
`default_nettype wire

// File: rtl/gmem_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gmem_fifo_ctrl
// Description : Sequences an external simple dual-port RAM (registered read
//               address, output register with load enable) into a
//               first-word-fall-through FIFO of DEPTH words: DEPTH-1 words
//               in RAM plus one in the RAM output register.
// Ports       : clk, reset (sync, active-high)
//               s_valid/s_ready/s_data  - write side handshake
//               m_valid/m_ready/m_data  - read side handshake (m_data = mem_dout)
//               mem_*                   - RAM write port and read port control
//               usedw                   - total occupancy (optional)
// Options     : GMEM_FIFO_CTRL_USEDW_EN adds the registered usedw output.
// Revision    : 1.0 - initial release
// ============================================================================
module gmem_fifo_ctrl
  import gmem_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef GMEM_FIFO_CTRL_USEDW_EN
  output logic [ADDR_WIDTH:0]   usedw,
`endif
  output logic                  mem_clk_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [ADDR_WIDTH:0] c_ram_full = (ADDR_WIDTH + 1)'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_s_ready;
  logic                  r_m_valid;

  logic                  w_push;
  logic                  w_ram_pop;
  logic                  w_m_valid_nxt;
  logic [ADDR_WIDTH-1:0] w_wptr_inc;
  logic [ADDR_WIDTH-1:0] w_rptr_inc;
  logic [ADDR_WIDTH-1:0] w_rptr_nxt;
  logic [ADDR_WIDTH:0]   w_ram_cnt_nxt;

  assign w_push    = s_valid & r_s_ready;
  // A word leaves RAM whenever the output stage is empty or being drained.
  // ram_cnt only counts words written at earlier edges, so the word being
  // written this edge is never read at the same address this edge.
  assign w_ram_pop = (r_ram_cnt != '0) & (~r_m_valid | m_ready);

  assign w_wptr_inc = ADDR_WIDTH'(ptr_inc(32'(r_wptr), DEPTH));
  assign w_rptr_inc = ADDR_WIDTH'(ptr_inc(32'(r_rptr), DEPTH));
  assign w_rptr_nxt = w_ram_pop ? w_rptr_inc : r_rptr;

  assign w_m_valid_nxt = w_ram_pop | (r_m_valid & ~m_ready);

  always_comb begin
    w_ram_cnt_nxt = r_ram_cnt;
    if (w_push && !w_ram_pop) begin
      w_ram_cnt_nxt = r_ram_cnt + 1'b1;
    end else if (!w_push && w_ram_pop) begin
      w_ram_cnt_nxt = r_ram_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= w_wptr_inc;
      end
      r_rptr    <= w_rptr_nxt;
      r_ram_cnt <= w_ram_cnt_nxt;
      r_s_ready <= (w_ram_cnt_nxt != c_ram_full);
      r_m_valid <= w_m_valid_nxt;
    end
  end

`ifdef GMEM_FIFO_CTRL_USEDW_EN
  logic [ADDR_WIDTH:0] r_usedw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_usedw <= '0;
    end else begin
      r_usedw <= w_ram_cnt_nxt + {{ADDR_WIDTH{1'b0}}, w_m_valid_nxt};
    end
  end

  assign usedw = r_usedw;
`endif

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = mem_dout;

  assign mem_clk_en = 1'b1;
  assign mem_we     = w_push;
  assign mem_waddr  = r_wptr;
  assign mem_din    = s_data;
  // The RAM captures this every edge; presenting the next read pointer
  // keeps the captured address equal to rptr, so a pop takes one edge.
  assign mem_raddr  = w_rptr_nxt;
  assign mem_re     = w_ram_pop;

endmodule : gmem_fifo_ctrl
`default_nettype wire

// File: tb/tb_gmem_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gmem_fifo_ctrl
// Description : Self-checking bench for gmem_fifo_ctrl with a behavioural
//               registered-read RAM and a reference queue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmem_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DP = 63;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          mem_clk_en;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_din;
  logic [AW-1:0] mem_raddr;
  logic          mem_re;
  logic [DW-1:0] mem_dout;
`ifdef GMEM_FIFO_CTRL_USEDW_EN
  logic [AW:0]   usedw;
`endif

  always #5 clk = ~clk;

  gmem_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
`ifdef GMEM_FIFO_CTRL_USEDW_EN
    .usedw      (usedw),
`endif
    .mem_clk_en (mem_clk_en),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_din    (mem_din),
    .mem_raddr  (mem_raddr),
    .mem_re     (mem_re),
    .mem_dout   (mem_dout)
  );

  // Behavioural RAM: address captured at edge N, output loaded at N+1
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [AW-1:0] ram_raddr_q;

  always_ff @(posedge clk) begin
    if (mem_clk_en) begin
      if (mem_we) ram[mem_waddr] <= mem_din;
      ram_raddr_q <= mem_raddr;
      if (reset)       mem_dout <= '0;
      else if (mem_re) mem_dout <= ram[ram_raddr_q];
    end
  end

  int            n_total = 0;
  int            n_bad   = 0;
  int            n_push  = 0;
  int            n_pop   = 0;
  logic [DW-1:0] sb [$];
  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at the negedge, evaluate handshakes, cross posedge
  task automatic cyc(input logic sv, input logic [DW-1:0] d, input logic mr);
    logic [DW-1:0] exp_word;
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    #1;
    if (hold_prev) begin
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_data", 64'(m_data), 64'(hold_data));
    end
    if (s_valid && s_ready) begin
      sb.push_back(d);
      n_push++;
    end
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("pop_when_empty", 64'(sb.size()), 64'd1);
      end else begin
        exp_word = sb.pop_front();
        chk("data", 64'(m_data), 64'(exp_word));
      end
      n_pop++;
    end
    hold_prev = m_valid && !m_ready;
    hold_data = m_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    hold_prev = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !m_valid) break;
      cyc(1'b0, '0, 1'b1);
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int q0;
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data",  64'(m_data),  64'd0);
`ifdef GMEM_FIFO_CTRL_USEDW_EN
    chk("rst_usedw", 64'(usedw), 64'd0);
`endif

    // Single word latency
    cyc(1'b1, 32'hA5A5_A5A5, 1'b0);
    chk("lat_edge1_m_valid", 64'(m_valid), 64'd0);
    cyc(1'b0, '0, 1'b0);
    chk("lat_edge2_m_valid", 64'(m_valid), 64'd1);
    chk("lat_m_data", 64'(m_data), 64'hA5A5_A5A5);
    cyc(1'b0, '0, 1'b1);
    chk("single_m_valid", 64'(m_valid), 64'd0);
    chk("single_s_ready", 64'(s_ready), 64'd1);

    // Fill to capacity; extra s_valid beats must be ignored
    for (int i = 0; i < 70; i++) cyc(1'b1, DW'(i), 1'b0);
    chk("fill_count", 64'(sb.size()), 64'd63);
    chk("full_s_ready", 64'(s_ready), 64'd0);
    chk("full_m_valid", 64'(m_valid), 64'd1);
`ifdef GMEM_FIFO_CTRL_USEDW_EN
    chk("full_usedw", 64'(usedw), 64'd63);
`endif
    // Pop and attempted push at the same edge while full
    p0 = n_push;
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("full_push_rejected", 64'(n_push - p0), 64'd0);
    chk("full_pop_s_ready", 64'(s_ready), 64'd1);
    cyc(1'b1, 32'h0000_0100, 1'b0);
    chk("refill_accepted", 64'(n_push - p0), 64'd1);
    chk("refull_s_ready", 64'(s_ready), 64'd0);
    drain("fill_drain");
    chk("drained_s_ready", 64'(s_ready), 64'd1);

    // Streaming 200 words, wrapping the RAM pointers several times
    p0 = n_pop;
    q0 = n_push;
    for (int i = 0; i < 200; i++) cyc(1'b1, DW'(1000 + i), 1'b1);
    chk("stream_pushes", 64'(n_push - q0), 64'd200);
    chk("stream_pops", 64'(n_pop - p0), 64'd198);
    drain("stream_drain");

    // Random traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end
    drain("random_drain");
    chk("random_balance", 64'(n_push), 64'(n_pop));

    // Reset with 20 words queued
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(500 + i), 1'b0);
    chk("pre_reset_count", 64'(sb.size()), 64'd20);
    do_reset();
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd1);
`ifdef GMEM_FIFO_CTRL_USEDW_EN
    chk("mid_rst_usedw", 64'(usedw), 64'd0);
`endif
    cyc(1'b1, 32'h1, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("post_rst_m_valid", 64'(m_valid), 64'd1);
    chk("post_rst_first", 64'(m_data), 64'h1);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_gmem_fifo_ctrl
`default_nettype wire
